// File: rtl/rlwe_processor_array.sv
// rlwe_processor_array: NUM_CH RNS lanes (one rlwe_processor_part per prime) behind a
// valid/ready command FSM with per-lane enable mask, sticky per-lane done capture and a
// single op_done pulse.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   modulus_sel          forwarded to every lane
//   cmd_valid/cmd_ready  command handshake; ready only while idle
//   cmd_op               0=LD 1=AC 2=NC 3=CRT, picks which lane start line is released
//   cmd_instr, cmd_ntt_iter, cmd_add_conv, cmd_mask   latched on accept
//   rdMsel, wtMsel       RAM mux selects of the lowest-index enabled lane (0 if none)
//   ram_we, rd_addr, wr_addr, din_hi, din_lo, doutb   per-lane RAM bank interface
//   rom_addr, rom_w      per-lane twiddle ROM interface
//   done_vec             sticky per-lane done of the current op
//   op_done, op_err      one-cycle completion pulse, watchdog expiry flag
//
// Build option: define RLWE_ARRAY_WATCHDOG_EN to enable a RUN-cycle watchdog that ends the
// op after TIMEOUT_CYC cycles with op_err=1. Without it op_err is tied 0 and RUN waits.
//
// rlwe_processor_part (one RNS lane) lives in this file as well. Its start lines are
// active-low: the lane is held cleared while all four are 1 and runs while one is 0. It
// sweeps 40 + LANE + 32*ntt_iter coefficients, reading doutb/rom_w and writing back one
// cycle later, then raises done until its start line returns to 1.

module rlwe_processor_part #(
  parameter int unsigned LANE       = 0,
  parameter int unsigned CORE_INDEX = 1,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 30,
  parameter int unsigned ROM_AW     = 13
) (
  input  logic                clk,
  input  logic                modulus_sel,
  input  logic                rst_ld,
  input  logic                rst_ac,
  input  logic                rst_nc,
  input  logic                rst_crt,
  input  logic [1:0]          instr_ld,
  input  logic [1:0]          instr_nc,
  input  logic [1:0]          ntt_iter,
  input  logic                add_conv,
  output logic [1:0]          rd_msel,
  output logic [1:0]          wt_msel,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   din_hi,
  output logic [DATA_W-1:0]   din_lo,
  input  logic [2*DATA_W-1:0] doutb,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_w,
  output logic                done
);

  localparam logic [1:0] LaneId = 2'(LANE);
  localparam logic [1:0] CoreId = 2'(CORE_INDEX);

  logic              released;
  logic              busy;
  logic [7:0]        lat;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] dout_hi, dout_lo;

  assign released = ~(rst_ld & rst_ac & rst_nc & rst_crt);
  assign lat      = 8'(40 + LANE) + {1'b0, ntt_iter, 5'b0};
  assign done     = released & (cnt_q == lat);
  assign busy     = released & ~done;
  assign dout_hi  = doutb[2*DATA_W-1:DATA_W];
  assign dout_lo  = doutb[DATA_W-1:0];

  always_comb begin
    cnt_d     = '0;
    if (busy) begin
      cnt_d = cnt_q + 8'd1;
    end else if (released) begin
      cnt_d = cnt_q;
    end
    we_d      = busy;
    wr_addr_d = rd_addr;
  end

  always_ff @(posedge clk) begin
    cnt_q     <= cnt_d;
    we_q      <= we_d;
    wr_addr_q <= wr_addr_d;
  end

  assign rd_addr  = ADDR_W'(cnt_q);
  assign wr_addr  = wr_addr_q;
  // Write lags read by one cycle (RAM read latency); gated so an abort stops it at once.
  assign ram_we   = we_q & released;
  assign rom_addr = ROM_AW'({ntt_iter, cnt_q});
  assign din_hi   = modulus_sel ? (dout_hi - rom_w) : (dout_hi + rom_w);
  assign din_lo   = add_conv ? (dout_lo + dout_hi) : dout_lo;
  assign rd_msel  = instr_ld ^ LaneId;
  assign wt_msel  = instr_nc ^ LaneId ^ CoreId;

endmodule

module rlwe_processor_array #(
  parameter int unsigned NUM_CH      = 7,
  parameter int unsigned CORE_INDEX  = 1,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 30,
  parameter int unsigned ROM_AW      = 13,
  parameter int unsigned TIMEOUT_CYC = 1 << 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       modulus_sel,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_instr,
  input  logic [1:0]                 cmd_ntt_iter,
  input  logic                       cmd_add_conv,
  input  logic [NUM_CH-1:0]          cmd_mask,
  output logic [1:0]                 rdMsel,
  output logic [1:0]                 wtMsel,
  output logic [NUM_CH-1:0]          ram_we,
  output logic [NUM_CH*ADDR_W-1:0]   rd_addr,
  output logic [NUM_CH*ADDR_W-1:0]   wr_addr,
  output logic [NUM_CH*DATA_W-1:0]   din_hi,
  output logic [NUM_CH*DATA_W-1:0]   din_lo,
  input  logic [NUM_CH*2*DATA_W-1:0] doutb,
  output logic [NUM_CH*ROM_AW-1:0]   rom_addr,
  input  logic [NUM_CH*DATA_W-1:0]   rom_w,
  output logic [NUM_CH-1:0]          done_vec,
  output logic                       op_done,
  output logic                       op_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  localparam logic [1:0] OpLd  = 2'd0;
  localparam logic [1:0] OpAc  = 2'd1;
  localparam logic [1:0] OpNc  = 2'd2;
  localparam logic [1:0] OpCrt = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              issue_cnt_q, issue_cnt_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        instr_q, instr_d;
  logic [1:0]        iter_q, iter_d;
  logic              add_conv_q, add_conv_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] done_vec_q, done_vec_d;

`ifdef RLWE_ARRAY_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Lane-side signals
  logic [NUM_CH-1:0] lane_run;
  logic [NUM_CH-1:0] lane_rst_ld, lane_rst_ac, lane_rst_nc, lane_rst_crt;
  logic [NUM_CH-1:0] lane_done;
  logic [NUM_CH-1:0] lane_we;
  logic [1:0]        lane_rd_msel [NUM_CH];
  logic [1:0]        lane_wt_msel [NUM_CH];

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    op_d        = op_q;
    instr_d     = instr_q;
    iter_d      = iter_q;
    add_conv_d  = add_conv_q;
    mask_d      = mask_q;
    done_vec_d  = done_vec_q;
`ifdef RLWE_ARRAY_WATCHDOG_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d        = cmd_op;
          instr_d     = cmd_instr;
          iter_d      = cmd_ntt_iter;
          add_conv_d  = cmd_add_conv;
          mask_d      = cmd_mask;
          issue_cnt_d = 1'b0;
          state_d     = StIssue;
`ifdef RLWE_ARRAY_WATCHDOG_EN
          wd_d        = '0;
          err_d       = 1'b0;
`endif
        end
      end
      StIssue: begin
        // Two flush cycles with every start line high so lanes drop any stale state.
        done_vec_d  = '0;
        issue_cnt_d = 1'b1;
        if (issue_cnt_q) begin
          issue_cnt_d = 1'b0;
          state_d     = (mask_q == '0) ? StFin : StRun;
        end
      end
      StRun: begin
        done_vec_d = done_vec_q | (lane_done & mask_q);
        // Completion uses the registered vector, adding one cycle of capture latency.
        if (&(done_vec_q | ~mask_q)) begin
          state_d = StFin;
        end
`ifdef RLWE_ARRAY_WATCHDOG_EN
        else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WdW'(TIMEOUT_CYC)) begin
            state_d = StFin;
            err_d   = 1'b1;
          end
        end
`endif
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      issue_cnt_q <= 1'b0;
      op_q        <= OpLd;
      instr_q     <= '0;
      iter_q      <= '0;
      add_conv_q  <= 1'b0;
      mask_q      <= '0;
      done_vec_q  <= '0;
`ifdef RLWE_ARRAY_WATCHDOG_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      op_q        <= op_d;
      instr_q     <= instr_d;
      iter_q      <= iter_d;
      add_conv_q  <= add_conv_d;
      mask_q      <= mask_d;
      done_vec_q  <= done_vec_d;
`ifdef RLWE_ARRAY_WATCHDOG_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign op_done   = (state_q == StFin);
  assign done_vec  = done_vec_q;
`ifdef RLWE_ARRAY_WATCHDOG_EN
  assign op_err    = op_done & err_q;
`else
  assign op_err    = 1'b0;
`endif

  // Start lines are decoded from registered state, so a reset returns them high on the
  // same edge that forces the FSM back to idle.
  assign lane_run     = {NUM_CH{state_q == StRun}} & mask_q;
  assign lane_rst_ld  = ~(lane_run & {NUM_CH{op_q == OpLd}});
  assign lane_rst_ac  = ~(lane_run & {NUM_CH{op_q == OpAc}});
  assign lane_rst_nc  = ~(lane_run & {NUM_CH{op_q == OpNc}});
  assign lane_rst_crt = ~(lane_run & {NUM_CH{op_q == OpCrt}});
  assign ram_we       = lane_we & mask_q;

  // Walk from the top so the lowest enabled lane is the one left standing.
  always_comb begin
    rdMsel = '0;
    wtMsel = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask_q[k]) begin
        rdMsel = lane_rd_msel[k];
        wtMsel = lane_wt_msel[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    rlwe_processor_part #(
      .LANE       (k),
      .CORE_INDEX (CORE_INDEX),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .ROM_AW     (ROM_AW)
    ) u_part (
      .clk         (clk),
      .modulus_sel (modulus_sel),
      .rst_ld      (lane_rst_ld[k]),
      .rst_ac      (lane_rst_ac[k]),
      .rst_nc      (lane_rst_nc[k]),
      .rst_crt     (lane_rst_crt[k]),
      .instr_ld    (instr_q),
      .instr_nc    (instr_q),
      .ntt_iter    (iter_q),
      .add_conv    (add_conv_q),
      .rd_msel     (lane_rd_msel[k]),
      .wt_msel     (lane_wt_msel[k]),
      .ram_we      (lane_we[k]),
      .rd_addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_addr     (wr_addr[k*ADDR_W +: ADDR_W]),
      .din_hi      (din_hi[k*DATA_W +: DATA_W]),
      .din_lo      (din_lo[k*DATA_W +: DATA_W]),
      .doutb       (doutb[k*2*DATA_W +: 2*DATA_W]),
      .rom_addr    (rom_addr[k*ROM_AW +: ROM_AW]),
      .rom_w       (rom_w[k*DATA_W +: DATA_W]),
      .done        (lane_done[k])
    );
  end

endmodule

// File: tb/tb_rlwe_processor_array.sv
// Scoreboard bench for rlwe_processor_array (NUM_CH=7). Each issued command pushes its
// expected completion edge, done_vec and op_err; a monitor pops on every op_done.
// Lane k runs 40 + k + 32*ntt_iter cycles, so op_done lands 44 + kmax + 32*iter edges after
// the accepting edge (2 for an empty mask).
module tb_rlwe_processor_array;
  localparam int NUM_CH = 7;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 30;
  localparam int ROM_AW = 13;
  localparam logic [DATA_W-1:0] DH = 30'h3000_0005;
  localparam logic [DATA_W-1:0] DL = 30'h0123_4567;
  localparam logic [DATA_W-1:0] RW = 30'h1000_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n, modulus_sel, cmd_valid, cmd_ready;
  logic [1:0]                 cmd_op, cmd_instr, cmd_ntt_iter;
  logic                       cmd_add_conv;
  logic [NUM_CH-1:0]          cmd_mask;
  logic [1:0]                 rdMsel, wtMsel;
  logic [NUM_CH-1:0]          ram_we, done_vec;
  logic [NUM_CH*ADDR_W-1:0]   rd_addr, wr_addr;
  logic [NUM_CH*DATA_W-1:0]   din_hi, din_lo, rom_w;
  logic [NUM_CH*2*DATA_W-1:0] doutb;
  logic [NUM_CH*ROM_AW-1:0]   rom_addr;
  logic                       op_done, op_err;

  assign doutb = {NUM_CH{DH, DL}};
  assign rom_w = {NUM_CH{RW}};

  rlwe_processor_array #(
    .NUM_CH(NUM_CH), .CORE_INDEX(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_AW(ROM_AW),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .modulus_sel(modulus_sel), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_instr(cmd_instr),
    .cmd_ntt_iter(cmd_ntt_iter), .cmd_add_conv(cmd_add_conv), .cmd_mask(cmd_mask),
    .rdMsel(rdMsel), .wtMsel(wtMsel), .ram_we(ram_we), .rd_addr(rd_addr),
    .wr_addr(wr_addr), .din_hi(din_hi), .din_lo(din_lo), .doutb(doutb),
    .rom_addr(rom_addr), .rom_w(rom_w), .done_vec(done_vec), .op_done(op_done),
    .op_err(op_err)
  );

  typedef struct {
    int                at_cyc;
    logic [NUM_CH-1:0] dv;
    logic              err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc = 0;
  int   cur_op = 0;
  logic [NUM_CH-1:0] cur_mask = '0;
  int   stray_cnt = 0;
  int   rel_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && op_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_op_done", 64'(op_done), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("op_done_cycle", 64'(cyc), 64'(e.at_cyc));
        chk("op_done_vec", 64'(done_vec), 64'(e.dv));
        chk("op_err", 64'(op_err), 64'(e.err));
      end
    end
  end

  // Start-line / write-enable watcher: only the current op's line may go low and only
  // inside the current mask; no write from a masked-off lane.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [NUM_CH-1:0] zl [4];
      zl[0] = ~dut.lane_rst_ld;
      zl[1] = ~dut.lane_rst_ac;
      zl[2] = ~dut.lane_rst_nc;
      zl[3] = ~dut.lane_rst_crt;
      for (int o = 0; o < 4; o++) begin
        if (o == cur_op) begin
          if (|(zl[o] & ~cur_mask)) stray_cnt++;
          if (|zl[o]) rel_cnt++;
        end else if (|zl[o]) begin
          stray_cnt++;
        end
      end
      if (|(ram_we & ~cur_mask)) stray_cnt++;
    end
  end

  task automatic issue(input int op, input logic [1:0] instr, input logic [1:0] iter,
                       input logic ac, input logic [NUM_CH-1:0] mask);
    @(negedge clk);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cur_op       = op;
    cur_mask     = mask;
    cmd_valid    = 1'b1;
    cmd_op       = 2'(op);
    cmd_instr    = instr;
    cmd_ntt_iter = iter;
    cmd_add_conv = ac;
    cmd_mask     = mask;
    @(negedge clk);
    cmd_valid    = 1'b0;
    acc          = cyc;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic expect_done(input int lat, input logic [NUM_CH-1:0] dv, input logic err);
    exp_t e;
    e.at_cyc = acc + lat;
    e.dv     = dv;
    e.err    = err;
    q.push_back(e);
  endtask

  task automatic finish_op(input string name, input int s0, input int r0, input bit rel);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk({name, "_timeout"}, 64'(q.size()), 64'd0);
      q.delete();
    end
    chk({name, "_stray_release"}, 64'(stray_cnt - s0), 64'd0);
    chk({name, "_released"}, 64'(rel_cnt != r0), 64'(rel));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({name, "_op_done"}, 64'(op_done), 64'd0);
    chk({name, "_op_err"}, 64'(op_err), 64'd0);
    chk({name, "_done_vec"}, 64'(done_vec), 64'd0);
    chk({name, "_start_lines"},
        64'({dut.lane_rst_ld, dut.lane_rst_ac, dut.lane_rst_nc, dut.lane_rst_crt}),
        64'({4*NUM_CH{1'b1}}));
    chk({name, "_ram_we"}, 64'(ram_we), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0, r0;
    rst_n = 1'b0; modulus_sel = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_instr = '0;
    cmd_ntt_iter = '0; cmd_add_conv = 1'b0; cmd_mask = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // NC on all lanes; a second command offered mid-run must be ignored.
    s0 = stray_cnt; r0 = rel_cnt;
    issue(2, 2'd1, 2'd0, 1'b0, 7'h7F);
    expect_done(50, 7'h7F, 1'b0);
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_mask = 7'h01;
    repeat (3) @(negedge clk);
    chk("busy_ignores_valid", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    finish_op("nc_all", s0, r0, 1'b1);
    @(negedge clk);
    chk("done_vec_holds", 64'(done_vec), 64'h7F);

    // LD on lanes 0,2: selects from lane 0, datapath wraps modulo 2^30.
    s0 = stray_cnt; r0 = rel_cnt;
    issue(0, 2'd2, 2'd0, 1'b0, 7'h05);
    expect_done(46, 7'h05, 1'b0);
    chk("ld_rdMsel", 64'(rdMsel), 64'd2);
    chk("ld_wtMsel", 64'(wtMsel), 64'd3);
    repeat (12) @(negedge clk);
    chk("ld_rd_addr0", 64'(rd_addr[0 +: ADDR_W]), 64'd10);
    chk("ld_wr_addr0", 64'(wr_addr[0 +: ADDR_W]), 64'd9);
    chk("ld_rom_addr0", 64'(rom_addr[0 +: ROM_AW]), 64'd10);
    chk("ld_ram_we", 64'(ram_we), 64'h05);
    chk("ld_din_hi0", 64'(din_hi[0 +: DATA_W]), 64'h8);
    chk("ld_din_lo0", 64'(din_lo[0 +: DATA_W]), 64'(DL));
    finish_op("ld_05", s0, r0, 1'b1);

    // AC on lanes 1,2 with subtract / add_conv path: selects from lane 1.
    modulus_sel = 1'b1;
    s0 = stray_cnt; r0 = rel_cnt;
    issue(1, 2'd2, 2'd0, 1'b1, 7'h06);
    expect_done(46, 7'h06, 1'b0);
    chk("ac_rdMsel", 64'(rdMsel), 64'd3);
    chk("ac_wtMsel", 64'(wtMsel), 64'd2);
    repeat (12) @(negedge clk);
    chk("ac_din_hi1", 64'(din_hi[DATA_W +: DATA_W]), 64'h2000_0002);
    chk("ac_din_lo1", 64'(din_lo[DATA_W +: DATA_W]), 64'h3123_456C);
    finish_op("ac_06", s0, r0, 1'b1);
    modulus_sel = 1'b0;

    // Empty mask: straight to FIN, nothing released, selects read 0.
    s0 = stray_cnt; r0 = rel_cnt;
    issue(3, 2'd1, 2'd0, 1'b0, 7'h00);
    expect_done(2, 7'h00, 1'b0);
    chk("empty_rdMsel", 64'(rdMsel), 64'd0);
    finish_op("mask0", s0, r0, 1'b0);

    // Reset while lanes 0,1,4 done and lane 5 finishing on the very same edge.
    issue(2, 2'd0, 2'd0, 1'b0, 7'h33);
    repeat (47) @(negedge clk);
    chk("abort_done_vec_before", 64'(done_vec), 64'h13);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("abort");
    rst_n = 1'b1;

    // Lane 3 with ntt_iter=1 runs 75 cycles, beyond the 64-cycle watchdog.
    s0 = stray_cnt; r0 = rel_cnt;
    issue(3, 2'd0, 2'd1, 1'b0, 7'h08);
`ifdef RLWE_ARRAY_WATCHDOG_EN
    expect_done(66, 7'h00, 1'b1);
`else
    expect_done(79, 7'h08, 1'b0);
`endif
    finish_op("long_lane3", s0, r0, 1'b1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
